pht_update_scheduler: RTL and testbench

- Buffers pattern-history-table (PHT) counter updates produced by committed conditional branches.
- The PHT block RAM has a single port shared with fetch-stage prediction reads. This block queues up to UPDATE_WIDTH updates per cycle and drains one per cycle whenever fetch is not using the port.
- Sits between the commit-side branch-result path and the PHT RAM write port.
- Raises backpressure to commit when it cannot accept a full group of updates.

---
 rtl/pht_update_scheduler_pkg.sv | 32 +++
 rtl/pht_update_queue_ram.sv | 46 ++++
 rtl/pht_update_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_pht_update_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pht_update_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// pht_update_scheduler_pkg
// Shared definitions for the PHT update scheduler: default configuration
// values and the queue-side data types (index, counter value, queue pointer,
// queue occupancy count and the queued update record).
// ---------------------------------------------------------------------------
package pht_update_scheduler_pkg;

  localparam int DEF_PHT_ENTRY_NUM   = 2048;
  localparam int DEF_PHT_ENTRY_WIDTH = 2;
  localparam int DEF_PHT_QUEUE_SIZE  = 32;
  localparam int DEF_UPDATE_WIDTH    = 2;

  localparam int PHT_INDEX_BIT_WIDTH      = $clog2(DEF_PHT_ENTRY_NUM);
  localparam int PHT_QUEUE_SIZE_BIT_WIDTH = $clog2(DEF_PHT_QUEUE_SIZE);

  typedef logic [PHT_INDEX_BIT_WIDTH-1:0]      PHT_IndexPath;
  typedef logic [DEF_PHT_ENTRY_WIDTH-1:0]      PHT_EntryPath;
  typedef logic [PHT_QUEUE_SIZE_BIT_WIDTH-1:0] PhtQueuePointerPath;
  typedef logic [PHT_QUEUE_SIZE_BIT_WIDTH:0]   PhtQueueCountPath;

  typedef struct packed {
    PHT_IndexPath index;
    PHT_EntryPath value;
  } PhtUpdateQueueEntry;

  // True when n is a non-zero power of two (queue depth sanity check).
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/pht_update_queue_ram.sv
// ---------------------------------------------------------------------------
// pht_update_queue_ram
// Register array holding queued PHT updates. NWR write ports are applied in
// ascending port order, so a higher-numbered port wins when two ports hit the
// same address in one cycle. The single read port is combinational from the
// registered array.
// Ports:
//   clk    in  clock
//   we     in  NWR    per-port write enable
//   waddr  in  NWR*AW per-port write address
//   wdata  in  NWR*DW per-port write data
//   raddr  in  AW     read address (queue head)
//   rdata  out DW     read data
// ---------------------------------------------------------------------------
module pht_update_queue_ram #(
  parameter int DEPTH = 32,
  parameter int DW    = 13,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic [NWR-1:0]           we,
  input  logic [NWR-1:0][AW-1:0]   waddr,
  input  logic [NWR-1:0][DW-1:0]   wdata,
  input  logic [AW-1:0]            raddr,
  output logic [DW-1:0]            rdata
);

  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [DEPTH-1:0][DW-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < NWR; p++) begin
      if (we[p]) mem_d[waddr[p]] = wdata[p];
    end
  end

  // Contents are don't-care after reset; the scheduler's count guards reads.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pht_update_scheduler.sv
// ---------------------------------------------------------------------------
// pht_update_scheduler
// Queues PHT counter updates from committed branches and drains them, one per
// cycle, into the single-port PHT RAM whenever fetch is not reading it.
//
// Handshake: commit may present updates on any lane only while full is low;
// full low guarantees room for a complete group of UPDATE_WIDTH lanes.
// Lanes offered while there is no room are dropped and overflow latches.
//
// Optional build macro: PHT_UPDATE_COALESCE_EN -- an incoming lane whose
// index equals the most recently enqueued (still queued, not leaving this
// cycle) entry overwrites that entry's value instead of allocating a slot.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   updateValid  in   UPDATE_WIDTH         per-lane update request
//   updateIndex  in   UPDATE_WIDTH*IDX_W   per-lane PHT index (lane 0 LSBs)
//   updateValue  in   UPDATE_WIDTH*EW      per-lane new counter value
//   portBusy     in   fetch owns the PHT port this cycle
//   phtWE        out  PHT write enable
//   phtWA        out  PHT write address (head entry)
//   phtWV        out  PHT write value (head entry)
//   full         out  free entries < UPDATE_WIDTH
//   empty        out  queue holds no entries
//   overflow     out  sticky: an update was dropped
// ---------------------------------------------------------------------------
module pht_update_scheduler #(
  parameter int PHT_ENTRY_NUM   = pht_update_scheduler_pkg::DEF_PHT_ENTRY_NUM,
  parameter int PHT_ENTRY_WIDTH = pht_update_scheduler_pkg::DEF_PHT_ENTRY_WIDTH,
  parameter int QUEUE_SIZE      = pht_update_scheduler_pkg::DEF_PHT_QUEUE_SIZE,
  parameter int UPDATE_WIDTH    = pht_update_scheduler_pkg::DEF_UPDATE_WIDTH,
  parameter int IDX_W           = $clog2(PHT_ENTRY_NUM)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [UPDATE_WIDTH-1:0]               updateValid,
  input  logic [UPDATE_WIDTH*IDX_W-1:0]         updateIndex,
  input  logic [UPDATE_WIDTH*PHT_ENTRY_WIDTH-1:0] updateValue,
  input  logic                                  portBusy,
  output logic                                  phtWE,
  output logic [IDX_W-1:0]                      phtWA,
  output logic [PHT_ENTRY_WIDTH-1:0]            phtWV,
  output logic                                  full,
  output logic                                  empty,
  output logic                                  overflow
);
  import pht_update_scheduler_pkg::*;

  localparam int EW = PHT_ENTRY_WIDTH;
  localparam int PW = $clog2(QUEUE_SIZE);
  localparam int CW = PW + 1;
  localparam int DW = IDX_W + EW;

  // Elaboration-time sanity check on the queue geometry.
  localparam bit QUEUE_OK = is_pow2(QUEUE_SIZE) && (QUEUE_SIZE >= UPDATE_WIDTH);
  if (!QUEUE_OK) begin : g_bad_queue
    queue_size_must_be_pow2_and_at_least_update_width u_bad ();
  end

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [CW-1:0] free_slots;
  logic [CW-1:0] accepted;
  logic          deq;
  logic          drop;
  logic [IDX_W-1:0] lane_idx;
  logic [EW-1:0]    lane_val;
  logic             coal_hit;

  logic [UPDATE_WIDTH-1:0]         wr_en;
  logic [UPDATE_WIDTH-1:0][PW-1:0] wr_addr;
  logic [UPDATE_WIDTH-1:0][DW-1:0] wr_data;
  logic [DW-1:0]                   rd_data;

`ifdef PHT_UPDATE_COALESCE_EN
  // Index of the newest queued entry; only meaningful while count_q != 0.
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic             cur_valid;
  logic [IDX_W-1:0] cur_idx;
  logic [PW-1:0]    cur_addr;
`endif

  always_comb begin
    // Reset cycle issues no write even if entries are still queued.
    deq        = !rst && (count_q != '0) && !portBusy;
    free_slots = CW'(QUEUE_SIZE) - count_q;
    accepted   = '0;
    drop       = 1'b0;
    lane_idx   = '0;
    lane_val   = '0;
    coal_hit   = 1'b0;
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
`ifdef PHT_UPDATE_COALESCE_EN
    // The newest entry is a coalescing target only if it survives this cycle.
    cur_valid  = (count_q != '0) && !(deq && (count_q == CW'(1)));
    cur_idx    = last_idx_q;
    cur_addr   = tail_q - PW'(1);
`endif
    for (int lane = 0; lane < UPDATE_WIDTH; lane++) begin
      lane_idx = updateIndex[lane*IDX_W +: IDX_W];
      lane_val = updateValue[lane*EW +: EW];
      coal_hit = 1'b0;
      if (updateValid[lane]) begin
`ifdef PHT_UPDATE_COALESCE_EN
        coal_hit = cur_valid && (lane_idx == cur_idx);
        if (coal_hit) begin
          wr_en[lane]   = 1'b1;
          wr_addr[lane] = cur_addr;
          wr_data[lane] = {lane_idx, lane_val};
        end
`endif
        if (!coal_hit) begin
          if (accepted < free_slots) begin
            // Compaction: the k-th accepted lane lands at tail + k.
            wr_en[lane]   = 1'b1;
            wr_addr[lane] = tail_q + PW'(accepted);
            wr_data[lane] = {lane_idx, lane_val};
            accepted      = accepted + CW'(1);
`ifdef PHT_UPDATE_COALESCE_EN
            cur_valid     = 1'b1;
            cur_idx       = lane_idx;
            cur_addr      = wr_addr[lane];
`endif
          end else begin
            drop = 1'b1;
          end
        end
      end
    end
    head_d     = head_q + PW'(deq);
    tail_d     = tail_q + PW'(accepted);
    count_d    = count_q + accepted - CW'(deq);
    overflow_d = overflow_q | drop;
`ifdef PHT_UPDATE_COALESCE_EN
    last_idx_d = cur_idx;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef PHT_UPDATE_COALESCE_EN
  always_ff @(posedge clk) begin
    last_idx_q <= last_idx_d;
  end
`endif

  pht_update_queue_ram #(
    .DEPTH (QUEUE_SIZE),
    .DW    (DW),
    .NWR   (UPDATE_WIDTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (head_q),
    .rdata (rd_data)
  );

  assign phtWE    = deq;
  assign phtWA    = rd_data[DW-1:EW];
  assign phtWV    = rd_data[EW-1:0];
  assign full     = (CW'(QUEUE_SIZE) - count_q) < CW'(UPDATE_WIDTH);
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pht_update_scheduler.sv
module tb_pht_update_scheduler;

  localparam int IDX_W = 11;
  localparam int EW    = 2;
  localparam int UW    = 2;
  localparam int DW    = IDX_W + EW;

  logic                clk = 1'b0;
  logic                rst;
  logic [UW-1:0]       updateValid;
  logic [UW*IDX_W-1:0] updateIndex;
  logic [UW*EW-1:0]    updateValue;
  logic                portBusy;
  logic                phtWE;
  logic [IDX_W-1:0]    phtWA;
  logic [EW-1:0]       phtWV;
  logic                full;
  logic                empty;
  logic                overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  pht_update_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .updateValid (updateValid),
    .updateIndex (updateIndex),
    .updateValue (updateValue),
    .portBusy    (portBusy),
    .phtWE       (phtWE),
    .phtWA       (phtWA),
    .phtWV       (phtWV),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [UW-1:0] v,
                       input logic [IDX_W-1:0] i0, input logic [EW-1:0] v0,
                       input logic [IDX_W-1:0] i1, input logic [EW-1:0] v1);
    updateValid = v;
    updateIndex = {i1, i0};
    updateValue = {v1, v0};
  endtask

  task automatic idle_lanes();
    updateValid = '0;
    updateIndex = '0;
    updateValue = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; portBusy = 1'b0; idle_lanes();
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (phtWE !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", phtWE); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    step();
  endtask

  task automatic test_two_lanes();
    logic [DW-1:0] e;
    portBusy = 1'b0;
    drive(2'b11, 11'h012, 2'd3, 11'h040, 2'd0);
    exp_q.push_back({11'h012, 2'd3});
    exp_q.push_back({11'h040, 2'd0});
    step();
    idle_lanes();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (phtWE !== 1'b1 || {phtWA, phtWV} !== e) begin
        n_fail++; $display("FAIL two_lanes[%0d] got we=%b wa/wv=%h exp we=1 wa/wv=%h", k, phtWE, {phtWA, phtWV}, e);
      end
      step();
    end
    @(negedge clk);
    n_tests++; if (empty !== 1'b1 || phtWE !== 1'b0) begin n_fail++; $display("FAIL two_lanes_empty got empty=%b we=%b exp 1/0", empty, phtWE); end
    step();
  endtask

  task automatic test_compact();
    portBusy = 1'b0;
    // Lane 0 carries junk but is invalid; only the last lane must be queued.
    drive(2'b10, 11'h3FF, 2'd1, 11'h155, 2'd2);
    step();
    idle_lanes();
    @(negedge clk);
    n_tests++;
    if (phtWE !== 1'b1 || phtWA !== 11'h155 || phtWV !== 2'd2) begin
      n_fail++; $display("FAIL compact_write got we=%b wa=%h wv=%0d exp we=1 wa=155 wv=2", phtWE, phtWA, phtWV);
    end
    step();
    @(negedge clk);
    n_tests++; if (empty !== 1'b1 || phtWE !== 1'b0) begin n_fail++; $display("FAIL compact_single got empty=%b we=%b exp 1/0", empty, phtWE); end
    step();
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] e;
    logic [IDX_W-1:0] ia, ib;
    portBusy = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (!full) begin
        ia = 11'(11'h200 + 2 * c);
        ib = 11'(11'h201 + 2 * c);
        drive(2'b11, ia, ia[1:0], ib, ib[1:0]);
        exp_q.push_back({ia, ia[1:0]});
        exp_q.push_back({ib, ib[1:0]});
      end else begin
        idle_lanes();
      end
      step();
    end
    idle_lanes();
    @(negedge clk);
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%b exp=1", full); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_overflow got=%b exp=0", overflow); end
    n_tests++; if (phtWE !== 1'b0) begin n_fail++; $display("FAIL fill_busy_we got=%b exp=0", phtWE); end
    step();
    portBusy = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (phtWE !== 1'b1 || {phtWA, phtWV} !== e) begin
        n_fail++; $display("FAIL fill_drain[%0d] got we=%b wa/wv=%h exp we=1 wa/wv=%h", k, phtWE, {phtWA, phtWV}, e);
      end
      step();
    end
    @(negedge clk);
    n_tests++; if (empty !== 1'b1 || phtWE !== 1'b0) begin n_fail++; $display("FAIL fill_end got empty=%b we=%b exp 1/0", empty, phtWE); end
    step();
  endtask

  task automatic test_overflow();
    logic [DW-1:0] e;
    logic [IDX_W-1:0] ia, ib;
    portBusy = 1'b1;
    for (int c = 0; c < 15; c++) begin
      ia = 11'(11'h300 + 2 * c);
      ib = 11'(11'h301 + 2 * c);
      drive(2'b11, ia, ib[1:0], ib, ia[1:0]);
      exp_q.push_back({ia, ib[1:0]});
      exp_q.push_back({ib, ia[1:0]});
      step();
    end
    drive(2'b01, 11'h31E, 2'd3, 11'h000, 2'd0);
    exp_q.push_back({11'h31E, 2'd3});
    step();
    idle_lanes();
    @(negedge clk);
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_31_full got=%b exp=1", full); end
    step();
    // Illegal producer: two lanes with a single free slot.
    drive(2'b11, 11'h3A1, 2'd2, 11'h3A2, 2'd1);
    exp_q.push_back({11'h3A1, 2'd2});
    step();
    idle_lanes();
    @(negedge clk);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got=%b exp=1", full); end
    step();
    portBusy = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (phtWE !== 1'b1 || {phtWA, phtWV} !== e) begin
        n_fail++; $display("FAIL ovf_drain[%0d] got we=%b wa/wv=%h exp we=1 wa/wv=%h", k, phtWE, {phtWA, phtWV}, e);
      end
      step();
    end
    @(negedge clk);
    n_tests++; if (empty !== 1'b1 || phtWE !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped_lane got empty=%b we=%b exp 1/0", empty, phtWE); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    step();
  endtask

  task automatic test_reset_mid();
    portBusy = 1'b1;
    drive(2'b11, 11'h050, 2'd1, 11'h051, 2'd2); step();
    drive(2'b11, 11'h052, 2'd3, 11'h053, 2'd0); step();
    drive(2'b01, 11'h054, 2'd1, 11'h000, 2'd0); step();
    idle_lanes();
    rst = 1'b1;
    portBusy = 1'b0;
    @(negedge clk);
    n_tests++; if (phtWE !== 1'b0) begin n_fail++; $display("FAIL rstmid_we_in_reset got=%b exp=0", phtWE); end
    step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (phtWE !== 1'b0) begin n_fail++; $display("FAIL rstmid_we_after got=%b exp=0", phtWE); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_overflow got=%b exp=0", overflow); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL rstmid_full got=%b exp=0", full); end
    step();
  endtask

  task automatic test_coalesce();
    logic [DW-1:0] e;
    int n_exp;
    portBusy = 1'b1;
    drive(2'b01, 11'h007, 2'd1, 11'h000, 2'd0); step();
    drive(2'b01, 11'h007, 2'd2, 11'h000, 2'd0); step();
    idle_lanes();
`ifdef PHT_UPDATE_COALESCE_EN
    exp_q.push_back({11'h007, 2'd2});
    n_exp = 1;
`else
    exp_q.push_back({11'h007, 2'd1});
    exp_q.push_back({11'h007, 2'd2});
    n_exp = 2;
`endif
    portBusy = 1'b0;
    for (int k = 0; k < n_exp; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (phtWE !== 1'b1 || {phtWA, phtWV} !== e) begin
        n_fail++; $display("FAIL coalesce[%0d] got we=%b wa/wv=%h exp we=1 wa/wv=%h", k, phtWE, {phtWA, phtWV}, e);
      end
      step();
    end
    @(negedge clk);
    n_tests++; if (empty !== 1'b1 || phtWE !== 1'b0) begin n_fail++; $display("FAIL coalesce_end got empty=%b we=%b exp 1/0", empty, phtWE); end
    step();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    portBusy = 1'b0;
    idle_lanes();
    test_reset();
    test_two_lanes();
    test_compact();
    test_fill_drain();
    test_overflow();
    test_reset_mid();
    test_coalesce();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
